// File: rtl/bicubic_block_scheduler.sv
// bicubic_block_scheduler: frame sequencer gating AC<->PE handshakes per column block.
// Optional SCHED_PERF_CNT_EN adds the stall_cnt output-backpressure counter.
module bicubic_block_scheduler #(
    parameter int BLOCK_SIZE   = 11,
    parameter int SRC_W        = 22,
    parameter int SRC_H        = 8,
    parameter int BUFFER_WIDTH = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ac_upsp_rvalid,
    output logic upsp_ac_rready,
    output logic pe_rvalid,
    input  logic pe_rready,
    input  logic pe_wvalid,
    output logic pe_wready,
    output logic upsp_ac_wvalid,
    input  logic ac_upsp_wready,
    output logic pe_flush,
    output logic busy,
    output logic frame_done,
    output logic [$clog2(SRC_W/BLOCK_SIZE+1)-1:0] cur_blk
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int NB        = SRC_W / BLOCK_SIZE;
    localparam int CW        = $clog2(NB + 1);
    localparam int IN_BEATS  = SRC_H * BLOCK_SIZE;
    localparam int OUT_BEATS = SRC_H * 4 * BLOCK_SIZE;
    localparam int IW        = $clog2(IN_BEATS + 1);
    localparam int OW        = $clog2(OUT_BEATS + 1);

    if (SRC_W % BLOCK_SIZE != 0 || BUFFER_WIDTH < 1) begin : g_cfg_err
        $error("bicubic_block_scheduler: SRC_W must be a multiple of BLOCK_SIZE");
    end

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, FLUSH, DONE} state_t;
    state_t state;
    logic [IW-1:0] in_cnt;
    logic [OW-1:0] out_cnt;
    logic in_open, out_open, in_acc, out_acc, in_last, out_last, blk_last;

    // Output gate also closes once the block's beat quota is met.
    always_comb begin
        in_open        = state == FEED;
        out_open       = (state == FEED || state == DRAIN) && out_cnt != OW'(OUT_BEATS);
        pe_rvalid      = in_open & ac_upsp_rvalid;
        upsp_ac_rready = in_open & pe_rready;
        upsp_ac_wvalid = out_open & pe_wvalid;
        pe_wready      = out_open & ac_upsp_wready;
        in_acc         = pe_rvalid & pe_rready;
        out_acc        = upsp_ac_wvalid & ac_upsp_wready;
        in_last        = in_acc && in_cnt == IW'(IN_BEATS - 1);
        out_last       = out_acc && out_cnt == OW'(OUT_BEATS - 1);
        blk_last       = cur_blk == CW'(NB - 1);
    end

    assign busy       = state != IDLE;
    assign pe_flush   = state == FLUSH;
    assign frame_done = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_blk <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            in_cnt  <= in_cnt + IW'(in_acc);
            out_cnt <= out_cnt + OW'(out_acc);
            case (state)
                IDLE: if (start) begin
                    state   <= FEED;
                    cur_blk <= '0;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end
                FEED:  if (in_last) state <= (out_last || out_cnt == OW'(OUT_BEATS)) ? FLUSH : DRAIN;
                DRAIN: if (out_last) state <= FLUSH;
                FLUSH: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    state   <= blk_last ? DONE : FEED;
                    cur_blk <= blk_last ? cur_blk : cur_blk + CW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start))
            stall_cnt <= '0;
        else if (upsp_ac_wvalid && !ac_upsp_wready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
